// File: rtl/layer_output_serializer.sv
// Collects one value per neuron from a parallel layer, then streams them out in
// neuron order over a valid/ready handshake. Optional ReLU on the output: OUTPUT_SERIALIZER_RELU_EN.
module layer_output_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons*dataWidth-1:0] neuronOut,
    input  logic [numNeurons-1:0]           neuronOutValid,
    output logic [dataWidth-1:0]            dataOut,
    output logic                            dataOutValid,
    input  logic                            dataOutReady,
    output logic                            layerDone,
    output logic                            overrun
);

    localparam int IDXW = $clog2(numNeurons);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(numNeurons - 1);

    typedef enum logic {COLLECT, SHIFT} state_t;

    state_t                          state_q, state_d;
    logic [dataWidth-1:0]            slot_q [numNeurons];
    logic [dataWidth-1:0]            slot_d [numNeurons];
    logic [numNeurons-1:0]           captured_q, captured_d;
    logic [IDXW-1:0]                 index_q, index_d;
    logic                            overrun_q, overrun_d;
    logic                            layer_done_q, layer_done_d;
    logic [dataWidth-1:0]            slot_sel;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        captured_d   = captured_q;
        index_d      = index_q;
        overrun_d    = overrun_q;
        layer_done_d = 1'b0;
        case (state_q)
            COLLECT: begin
                for (int n = 0; n < numNeurons; n++) begin
                    if (neuronOutValid[n]) begin
                        slot_d[n]     = neuronOut[n*dataWidth +: dataWidth];
                        captured_d[n] = 1'b1;
                    end
                end
                if (&captured_d) begin
                    state_d = SHIFT;
                    index_d = '0;
                end
            end
            SHIFT: begin
                // Pulses arriving while streaming (including the final-beat edge) are lost.
                if (|neuronOutValid) begin
                    overrun_d = 1'b1;
                end
                if (dataOutReady) begin
                    if (index_q == LAST_IDX) begin
                        state_d      = COLLECT;
                        captured_d   = '0;
                        index_d      = '0;
                        layer_done_d = 1'b1;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= COLLECT;
            captured_q   <= '0;
            index_q      <= '0;
            overrun_q    <= 1'b0;
            layer_done_q <= 1'b0;
            for (int n = 0; n < numNeurons; n++) begin
                slot_q[n] <= '0;
            end
        end else begin
            state_q      <= state_d;
            captured_q   <= captured_d;
            index_q      <= index_d;
            overrun_q    <= overrun_d;
            layer_done_q <= layer_done_d;
            slot_q       <= slot_d;
        end
    end

    assign slot_sel = slot_q[index_q];

`ifdef OUTPUT_SERIALIZER_RELU_EN
    assign dataOut = slot_sel[dataWidth-1] ? '0 : slot_sel;
`else
    assign dataOut = slot_sel;
`endif

    assign dataOutValid = (state_q == SHIFT);
    assign layerDone    = layer_done_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/layer_output_serializer.md
LAYER_OUTPUT_SERIALIZER -- requirements
Module: layer_output_serializer

Interface
REQ-001 Parameter numNeurons, default 30, number of neurons in the producing layer (>=2).
REQ-002 Parameter dataWidth, default 8, width of one neuron output in bits, two's complement.
REQ-003 Port clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port neuronOut  input  numNeurons*dataWidth  flat bus; neuron n occupies bits [n*dataWidth +: dataWidth].
REQ-006 Port neuronOutValid  input  numNeurons  per-neuron one-cycle pulse qualifying its slice of neuronOut.
REQ-007 Port dataOut  output  dataWidth  serialized neuron value for the next layer.
REQ-008 Port dataOutValid  output  1  dataOut holds a valid beat.
REQ-009 Port dataOutReady  input  1  downstream accepts a beat.
REQ-010 Port layerDone  output  1  one-cycle pulse after the last beat transfers.
REQ-011 Port overrun  output  1  sticky flag: a valid pulse was dropped.

Function
REQ-012 The block SHALL have two states, COLLECT and SHIFT, plus a numNeurons-slot register file, a numNeurons-bit captured mask and a $clog2(numNeurons)-bit index.
REQ-013 In COLLECT, each asserted neuronOutValid[n] SHALL write slice n into slot n and set captured[n] on the same edge; any number of bits may be asserted in one cycle.
REQ-014 In COLLECT, a repeated pulse for an already-captured neuron SHALL overwrite slot n (last value wins) without setting overrun.
REQ-015 On the edge where captured becomes all-ones (including bits set on that edge), state SHALL become SHIFT with index 0.
REQ-016 dataOutValid SHALL be 1 exactly when state is SHIFT; dataOut SHALL equal slot[index], so the first beat is visible the cycle after the final valid pulse.
REQ-017 A beat transfers on an edge with dataOutValid and dataOutReady both 1; index then increments by 1; dataOut and index SHALL hold stable while dataOutReady is 0.
REQ-018 On transfer of beat index numNeurons-1, the block SHALL return to COLLECT, clear captured, reset index to 0 and assert layerDone for exactly the next cycle.
REQ-019 Any neuronOutValid bit asserted while in SHIFT SHALL be dropped (slots unchanged) and SHALL set overrun, which stays 1 until reset.
REQ-020 A valid pulse on the same edge that returns SHIFT to COLLECT SHALL be dropped and flagged as in REQ-019.
REQ-021 The index SHALL never exceed numNeurons-1; no wrap-around into unused encodings.

Reset
REQ-022 While rst is 0 at a rising edge: state COLLECT, captured 0, index 0, all slots 0, dataOutValid 0, layerDone 0, overrun 0.
REQ-023 Reset mid-SHIFT or mid-COLLECT SHALL discard all partial data; the first cycle after release SHALL be a clean COLLECT.

Configuration
REQ-024 Macro OUTPUT_SERIALIZER_RELU_EN: when defined, dataOut SHALL be 0 whenever slot[index] is negative (MSB 1), else slot[index]; stored slots remain raw.
REQ-025 When OUTPUT_SERIALIZER_RELU_EN is undefined, dataOut SHALL equal slot[index] unmodified; no other behaviour changes.

Verification
REQ-026 numNeurons=4, pulse neurons 0..3 on separate cycles with 0x11,0x22,0x33,0x44, ready held 1 -> beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting the cycle after the last pulse, then layerDone for 1 cycle.
REQ-027 All 4 valid bits in one cycle with 0x01..0x04, ready toggling 1,0,1,0 -> each beat held while ready is 0; 4 beats in 8 cycles, order preserved.
REQ-028 Neuron 2 pulsed twice (0x05 then 0x06) before neuron 3 completes the set -> beat 2 is 0x06, overrun stays 0.
REQ-029 Pulse neuron 1 during SHIFT -> overrun rises and stays 1; serialized beats unchanged; next layer collects normally.
REQ-030 rst low for 1 cycle after beat 1 of SHIFT -> dataOutValid 0 next cycle, no layerDone; a fresh 4-neuron set serializes correctly.
REQ-031 Slot value 0x80 with OUTPUT_SERIALIZER_RELU_EN defined -> dataOut 0x00; undefined -> 0x80.
